// File: rtl/axi4lite_arbiter.sv
// rtl/axi4lite_arbiter.sv - two-master (IFU read-only, LSU full) to one-slave AXI4-Lite arbiter
module axi4lite_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    ifu_arvalid,
    input  logic [ADDR_WIDTH-1:0]   ifu_araddr,
    output logic                    ifu_arready,
    output logic                    ifu_rvalid,
    output logic [DATA_WIDTH-1:0]   ifu_rdata,
    output logic [1:0]              ifu_rresp,
    input  logic                    ifu_rready,

    input  logic                    lsu_arvalid,
    input  logic [ADDR_WIDTH-1:0]   lsu_araddr,
    output logic                    lsu_arready,
    output logic                    lsu_rvalid,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,
    output logic [1:0]              lsu_rresp,
    input  logic                    lsu_rready,
    input  logic                    lsu_awvalid,
    input  logic [ADDR_WIDTH-1:0]   lsu_awaddr,
    output logic                    lsu_awready,
    input  logic                    lsu_wvalid,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wstrb,
    output logic                    lsu_wready,
    output logic                    lsu_bvalid,
    output logic [1:0]              lsu_bresp,
    input  logic                    lsu_bready,

    output logic                    arvalid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arready,
    input  logic                    rvalid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    output logic                    rready,
    output logic                    awvalid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awready,
    output logic                    wvalid,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wready,
    input  logic                    bvalid,
    input  logic [1:0]              bresp,
    output logic                    bready
);

    typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

    localparam logic GRANT_IFU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

    state_t state;
    logic   last_rd_grant;
    logic   ar_done;
    logic   aw_done;
    logic   w_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            last_rd_grant <= GRANT_IFU;
            ar_done       <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Writes always win; reads alternate only when both masters contend.
                    if (lsu_awvalid) begin
                        state <= LSU_WR;
                    end else if (ifu_arvalid && lsu_arvalid) begin
                        if (last_rd_grant == GRANT_IFU) begin
                            state         <= LSU_RD;
                            last_rd_grant <= GRANT_LSU;
                        end else begin
                            state         <= IFU_RD;
                            last_rd_grant <= GRANT_IFU;
                        end
                    end else if (ifu_arvalid) begin
                        state         <= IFU_RD;
                        last_rd_grant <= GRANT_IFU;
                    end else if (lsu_arvalid) begin
                        state         <= LSU_RD;
                        last_rd_grant <= GRANT_LSU;
                    end
                end
                IFU_RD, LSU_RD: begin
                    if (arvalid && arready) begin
                        ar_done <= 1'b1;
                    end
                    if (rvalid && rready) begin
                        state   <= IDLE;
                        ar_done <= 1'b0;
                    end
                end
                LSU_WR: begin
                    if (awvalid && awready) begin
                        aw_done <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        w_done <= 1'b1;
                    end
                    if (bvalid && bready) begin
                        state   <= IDLE;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payloads are muxed, not registered: masters hold them stable until ready.
    always_comb begin
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = 2'b00;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = 2'b00;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        lsu_bresp   = 2'b00;
        arvalid     = 1'b0;
        araddr      = '0;
        rready      = 1'b0;
        awvalid     = 1'b0;
        awaddr      = '0;
        wvalid      = 1'b0;
        wdata       = '0;
        wstrb       = '0;
        bready      = 1'b0;
        case (state)
            IFU_RD: begin
                arvalid     = ifu_arvalid & ~ar_done;
                araddr      = ifu_araddr;
                ifu_arready = arready & ~ar_done;
                ifu_rvalid  = rvalid;
                ifu_rdata   = rdata;
                ifu_rresp   = rresp;
                rready      = ifu_rready;
            end
            LSU_RD: begin
                arvalid     = lsu_arvalid & ~ar_done;
                araddr      = lsu_araddr;
                lsu_arready = arready & ~ar_done;
                lsu_rvalid  = rvalid;
                lsu_rdata   = rdata;
                lsu_rresp   = rresp;
                rready      = lsu_rready;
            end
            LSU_WR: begin
                awvalid     = lsu_awvalid & ~aw_done;
                awaddr      = lsu_awaddr;
                lsu_awready = awready & ~aw_done;
                wvalid      = lsu_wvalid & ~w_done;
                wdata       = lsu_wdata;
                wstrb       = lsu_wstrb;
                lsu_wready  = wready & ~w_done;
                lsu_bvalid  = bvalid;
                lsu_bresp   = bresp;
                bready      = lsu_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi4lite_arbiter.sv
// tb/tb_axi4lite_arbiter.sv - directed self-checking bench for axi4lite_arbiter
module tb_axi4lite_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_bvalid, lsu_bready;
    logic [1:0]  lsu_bresp;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] araddr, rdata;
    logic [1:0]  rresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;

    int checks = 0;
    int failures = 0;

    axi4lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rready(ifu_rready),
        .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rready(lsu_rready),
        .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awready(lsu_awready),
        .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wready(lsu_wready),
        .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bready(lsu_bready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Caller has raised the requests while in IDLE; exp_lsu names the master that must win.
    task automatic rd_xact(input bit exp_lsu, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp, input string tag);
        #1;
        check({tag, ".idle_arvalid"}, arvalid, 0);
        tick;
        arready = 1'b1;
        #1;
        check({tag, ".arvalid"}, arvalid, 1);
        check({tag, ".araddr"}, araddr, addr);
        check({tag, ".g_arready"}, exp_lsu ? lsu_arready : ifu_arready, 1);
        check({tag, ".o_arready"}, exp_lsu ? ifu_arready : lsu_arready, 0);
        tick;
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        if (exp_lsu) lsu_rready = 1'b1; else ifu_rready = 1'b1;
        #1;
        check({tag, ".no_reissue"}, arvalid, 0);
        check({tag, ".g_arready_done"}, exp_lsu ? lsu_arready : ifu_arready, 0);
        check({tag, ".g_rvalid"}, exp_lsu ? lsu_rvalid : ifu_rvalid, 1);
        check({tag, ".g_rdata"}, exp_lsu ? lsu_rdata : ifu_rdata, data);
        check({tag, ".g_rresp"}, exp_lsu ? lsu_rresp : ifu_rresp, resp);
        check({tag, ".o_rvalid"}, exp_lsu ? ifu_rvalid : lsu_rvalid, 0);
        check({tag, ".o_rdata"}, exp_lsu ? ifu_rdata : lsu_rdata, 0);
        check({tag, ".rready"}, rready, 1);
        tick;
        rvalid = 1'b0; rdata = '0; rresp = '0; arready = 1'b0;
        if (exp_lsu) begin
            lsu_arvalid = 1'b0; lsu_rready = 1'b0;
        end else begin
            ifu_arvalid = 1'b0; ifu_rready = 1'b0;
        end
        #1;
        check({tag, ".back_idle"}, {ifu_rvalid, lsu_rvalid, rready}, 0);
    endtask

    initial begin
        rst = 1'b0;
        ifu_arvalid = 0; ifu_araddr = '0; ifu_rready = 0;
        lsu_arvalid = 0; lsu_araddr = '0; lsu_rready = 0;
        lsu_awvalid = 0; lsu_awaddr = '0; lsu_wvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_bready = 0;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;
        #3;
        check("reset.valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
        check("reset.readies", {ifu_arready, lsu_arready, lsu_awready, lsu_wready}, 0);
        check("reset.addr", {araddr, awaddr}, 0);
        tick;
        rst = 1'b1;

        // IFU read, arvalid one cycle after request
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0000;
        rd_xact(0, 32'h8000_0000, 32'hDEAD_BEEF, 2'b00, "t1");

        // Three contended reads: LSU, IFU, LSU
        ifu_arvalid = 1; ifu_araddr = 32'h0000_1000;
        lsu_arvalid = 1; lsu_araddr = 32'h0000_2000;
        rd_xact(1, 32'h0000_2000, 32'h1111_1111, 2'b00, "t2a");
        lsu_arvalid = 1;
        rd_xact(0, 32'h0000_1000, 32'h2222_2222, 2'b00, "t2b");
        ifu_arvalid = 1;
        rd_xact(1, 32'h0000_2000, 32'h3333_3333, 2'b00, "t2c");
        ifu_arvalid = 0;

        // LSU write, AW accepted a cycle before W; valids held to expose re-issue
        tick;
        lsu_awvalid = 1; lsu_awaddr = 32'hA000_03F8;
        lsu_wvalid = 1; lsu_wdata = 32'h41; lsu_wstrb = 4'h1;
        #1;
        check("t3.idle_awvalid", awvalid, 0);
        tick;
        awready = 1;
        #1;
        check("t3.aw", {awvalid, lsu_awready, wvalid, lsu_wready}, 4'b1110);
        check("t3.awaddr", awaddr, 32'hA000_03F8);
        check("t3.wpayload", {wdata, wstrb}, {32'h41, 4'h1});
        tick;
        wready = 1;
        #1;
        check("t3.w", {awvalid, lsu_awready, wvalid, lsu_wready}, 4'b0011);
        tick;
        #1;
        check("t3.done", {awvalid, lsu_awready, wvalid, lsu_wready}, 4'b0000);
        lsu_awvalid = 0; lsu_wvalid = 0; awready = 0; wready = 0;
        bvalid = 1; bresp = 2'b00; lsu_bready = 1;
        #1;
        check("t3.b", {lsu_bvalid, lsu_bresp, bready}, 4'b1001);
        tick;
        bvalid = 0; lsu_bready = 0;
        #1;
        check("t3.idle", {lsu_bvalid, awvalid, bready}, 0);

        // Write and IFU read together: write first
        lsu_awvalid = 1; lsu_awaddr = 32'h0000_0040;
        lsu_wvalid = 1; lsu_wdata = 32'h5A5A_5A5A; lsu_wstrb = 4'hF;
        ifu_arvalid = 1; ifu_araddr = 32'h0000_3000;
        tick;
        awready = 1; wready = 1; arready = 1;
        #1;
        check("t4.wr_grant", {awvalid, wvalid, arvalid, ifu_arready}, 4'b1100);
        tick;
        lsu_awvalid = 0; lsu_wvalid = 0; awready = 0; wready = 0;
        bvalid = 1; lsu_bready = 1;
        #1;
        check("t4.b_phase", {lsu_bvalid, arvalid, ifu_arready}, 3'b100);
        tick;
        bvalid = 0; lsu_bready = 0; arready = 0;
        rd_xact(0, 32'h0000_3000, 32'hCAFE_F00D, 2'b00, "t4r");

        // Error response passes through
        tick;
        lsu_arvalid = 1; lsu_araddr = 32'h0000_5000;
        rd_xact(1, 32'h0000_5000, 32'h0BAD_0BAD, 2'b10, "t5");

        // Reset in LSU_RD after AR accepted, with R pending
        tick;
        lsu_arvalid = 1; lsu_araddr = 32'h0000_6000;
        tick;
        arready = 1;
        tick;
        arready = 0;
        rvalid = 1; rdata = 32'h7777_7777; rresp = 2'b11;
        #1;
        check("t6.pre", lsu_rvalid, 1);
        rst = 1'b0;
        #1;
        check("t6.rst_out", {lsu_rvalid, lsu_rresp, rready, arvalid, lsu_arready}, 0);
        check("t6.rst_data", {araddr, lsu_rdata}, 0);
        lsu_arvalid = 0; rvalid = 0; rdata = '0; rresp = '0;
        tick;
        rst = 1'b1;
        ifu_arvalid = 1; ifu_araddr = 32'h0000_7000;
        rd_xact(0, 32'h0000_7000, 32'h1234_5678, 2'b00, "t6r");

        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
